cmd_stream_gen: RTL and testbench

CMD_STREAM_GEN -- requirements
Module: cmd_stream_gen

---
 rtl/cmd_stream_gen.sv | 177 +++++++++++++++++
 tb/tb_cmd_stream_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_stream_gen.sv
// Command stream generator: serialises triangle records fetched from an external ROM,
// then one end-of-band (EFB) command per band and a closing end-of-frame (EF) command.
module cmd_stream_gen #(
   parameter int REC_W     = 480,
   parameter int OUT_W     = 8,
   parameter int NUM_TRI   = 3,
   parameter int NUM_BANDS = 80,
   parameter int OPC_LSB   = 240,
   parameter int LOOP      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       rec_addr,
   input  logic [REC_W-1:0] rec_data,
   output logic [OUT_W-1:0] out_data,
   output logic             out_push,
   input  logic             out_full,
   input  logic             draw_next,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      frame_cnt
);

   localparam int BEATS = REC_W / OUT_W;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [7:0]       LAST_TRI  = 8'(NUM_TRI - 1);
   localparam logic [7:0]       BANDS     = 8'(NUM_BANDS);
   localparam logic [REC_W-1:0] EFB_REC   = REC_W'(8'h80) << OPC_LSB;
   localparam logic [REC_W-1:0] EF_REC    = REC_W'(8'h40) << OPC_LSB;

   typedef enum logic [2:0] {
      IDLE, FETCH, SEND_TRI, WAIT_BAND, SEND_EFB, SEND_EF
   } state_t;

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [7:0]       tri_idx_q, tri_idx_d;
   logic [7:0]       band_idx_q, band_idx_d;
   logic [BCW-1:0]   beat_q, beat_d;
   logic [REC_W-1:0] rec_q, rec_d;
   logic             band_ready_q, band_ready_d;
   logic             frame_done_q, frame_done_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             send;
   logic             last_push;

   assign send       = (state_q == SEND_TRI) || (state_q == SEND_EFB) || (state_q == SEND_EF);
   assign out_push   = send && !out_full;
   assign last_push  = out_push && (beat_q == LAST_BEAT);
   assign out_data   = rec_q[REC_W-1 -: OUT_W];
   assign rec_addr   = tri_idx_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

   always_comb begin
      // NOTE: every target gets its hold value first so no path through the case infers a latch.
      state_d      = state_q;
      phase_d      = phase_q;
      tri_idx_d    = tri_idx_q;
      band_idx_d   = band_idx_q;
      beat_d       = beat_q;
      rec_d        = rec_q;
      band_ready_d = band_ready_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;

      if (out_push) begin
         rec_d  = rec_q << OUT_W;
         beat_d = beat_q + 1'b1;
         if (state_q != SEND_TRI && beat_q == '0)
            band_ready_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = FETCH;
               phase_d      = 1'b0;
               tri_idx_d    = '0;
               band_idx_d   = '0;
               band_ready_d = 1'b1;
            end
         end
         FETCH: begin
            // Phase 0 presents the address, phase 1 captures the ROM's registered data.
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               rec_d   = rec_data;
               beat_d  = '0;
               state_d = SEND_TRI;
            end
         end
         SEND_TRI: begin
            if (last_push) begin
               beat_d = '0;
               if (tri_idx_q < LAST_TRI) begin
                  tri_idx_d = tri_idx_q + 8'd1;
                  state_d   = FETCH;
               end else begin
                  state_d = WAIT_BAND;
               end
            end
         end
         WAIT_BAND: begin
            if (band_ready_q) begin
               beat_d = '0;
               if (band_idx_q < BANDS) begin
                  rec_d   = EFB_REC;
                  state_d = SEND_EFB;
               end else begin
                  rec_d   = EF_REC;
                  state_d = SEND_EF;
               end
            end
         end
         SEND_EFB: begin
            if (last_push) begin
               beat_d     = '0;
               band_idx_d = band_idx_q + 8'd1;
               state_d    = WAIT_BAND;
            end
         end
         SEND_EF: begin
            if (last_push) begin
               beat_d       = '0;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               if (LOOP != 0) begin
                  state_d    = FETCH;
                  phase_d    = 1'b0;
                  tri_idx_d  = '0;
                  band_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A rasteriser request coinciding with a clear must not be lost.
      if (draw_next)
         band_ready_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      if (rst) begin
         state_q      <= IDLE;
         phase_q      <= 1'b0;
         tri_idx_q    <= '0;
         band_idx_q   <= '0;
         beat_q       <= '0;
         rec_q        <= '0;
         band_ready_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         tri_idx_q    <= tri_idx_d;
         band_idx_q   <= band_idx_d;
         beat_q       <= beat_d;
         rec_q        <= rec_d;
         band_ready_q <= band_ready_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_cmd_stream_gen.sv
// Directed bench for cmd_stream_gen: a single-frame instance for stream, stall, band
// handshake and reset-abort cases, plus a looping instance for frame counter wrap.
module tb_cmd_stream_gen;

   localparam int REC_W = 32;
   localparam int OUT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1, start = 1'b0, out_full = 1'b0;
   logic             draw_req = 1'b0, draw_auto = 1'b0, draw_next;
   logic [7:0]       rec_addr, out_data;
   logic [REC_W-1:0] rec_data;
   logic             out_push, busy, frame_done;
   logic [15:0]      frame_cnt;

   logic             start2 = 1'b0, full2 = 1'b0, draw2 = 1'b1;
   logic [7:0]       rec_addr2, out_data2;
   logic [REC_W-1:0] rec_data2;
   logic             out_push2, busy2, frame_done2;
   logic [15:0]      frame_cnt2;

   assign draw_next = draw_req | draw_auto;

   cmd_stream_gen #(.REC_W(REC_W), .OUT_W(OUT_W), .NUM_TRI(2), .NUM_BANDS(2),
                    .OPC_LSB(0), .LOOP(0)) dut (
      .clk(clk), .rst(rst), .start(start), .rec_addr(rec_addr), .rec_data(rec_data),
      .out_data(out_data), .out_push(out_push), .out_full(out_full), .draw_next(draw_next),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   cmd_stream_gen #(.REC_W(REC_W), .OUT_W(OUT_W), .NUM_TRI(2), .NUM_BANDS(2),
                    .OPC_LSB(0), .LOOP(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .rec_addr(rec_addr2), .rec_data(rec_data2),
      .out_data(out_data2), .out_push(out_push2), .out_full(full2), .draw_next(draw2),
      .busy(busy2), .frame_done(frame_done2), .frame_cnt(frame_cnt2)
   );

   function automatic logic [REC_W-1:0] rom_word(input logic [7:0] addr);
      case (addr)
         8'd0:    return 32'hA1A2A3A4;
         8'd1:    return 32'hB1B2B3B4;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   // Synchronous ROM: data appears the cycle after the address.
   always @(posedge clk) begin
      rec_data  <= rom_word(rec_addr);
      rec_data2 <= rom_word(rec_addr2);
   end

   logic [7:0] exp_bytes [20] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
                                  8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80,
                                  8'h00, 8'h00, 8'h00, 8'h40};

   logic [7:0]  q[$];
   logic [7:0]  q2[$];
   logic [15:0] cnt2_q[$];
   int          done_cnt = 0;
   int          draw_at  = -1;
   int          n_vec    = 0;
   int          n_miss   = 0;

   // Captures pushed beats; can raise draw_next in the very cycle a chosen beat is pushed.
   always @(negedge clk) begin
      if (out_push) begin
         draw_auto <= (q.size() + 1 == draw_at);
         q.push_back(out_data);
      end else begin
         draw_auto <= 1'b0;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (out_push2) q2.push_back(out_data2);
      if (frame_done2) cnt2_q.push_back(frame_cnt2);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; out_full = 1'b0; draw_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_draw();
      @(posedge clk); #1 draw_req = 1'b1;
      @(posedge clk); #1 draw_req = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, input string tag);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (q.size() >= n) break;
      end
      #1;
      check(tag, q.size() >= n, 1);
   endtask

   task automatic wait_done(input int dbase, input int budget, input string tag);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         if (done_cnt > dbase) break;
      end
      #1;
      check(tag, done_cnt > dbase, 1);
   endtask

   task automatic check_frame(input int base, input string tag);
      for (int i = 0; i < 20; i++)
         check($sformatf("%s_byte%0d", tag, i),
               (base + i < q.size()) ? q[base + i] : 8'hxx, exp_bytes[i]);
      check({tag, "_len"}, q.size() - base, 20);
   endtask

   task automatic finish_frame(input int base, input int dbase, input string tag);
      wait_bytes(base + 12, 100, {tag, "_reach12"});
      pulse_draw();
      wait_bytes(base + 16, 100, {tag, "_reach16"});
      pulse_draw();
      wait_bytes(base + 20, 100, {tag, "_reach20"});
      wait_done(dbase, 50, {tag, "_done"});
      repeat (10) @(posedge clk);
      @(negedge clk);
      check({tag, "_done_once"}, done_cnt - dbase, 1);
      check({tag, "_frame_cnt"}, frame_cnt, 16'd1);
      check({tag, "_busy_end"}, busy, 1'b0);
      check_frame(base, tag);
   endtask

   int base, dbase;

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_push", out_push, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_cnt", frame_cnt, 16'd0);
      check("rst_addr", rec_addr, 8'd0);
      check("rst_data", out_data, 8'd0);

      // Full frame; a start while busy must not disturb it
      base = q.size(); dbase = done_cnt;
      pulse_start();
      wait_bytes(base + 4, 100, "t1_reach4");
      pulse_start();
      finish_frame(base, dbase, "t1");

      // Five-cycle stall on the second beat
      do_reset();
      base = q.size(); dbase = done_cnt;
      pulse_start();
      wait_bytes(base + 1, 100, "t2_reach1");
      out_full = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t2_no_push_in_stall", q.size() - base, 1);
      out_full = 1'b0;
      @(negedge clk);
      check("t2_push_after_stall", out_push, 1'b1);
      check("t2_beat_after_stall", out_data, 8'hA2);
      finish_frame(base, dbase, "t2");

      // Stream parks after first EFB until draw_next
      do_reset();
      base = q.size(); dbase = done_cnt;
      pulse_start();
      wait_bytes(base + 12, 100, "t3_reach12");
      repeat (20) @(posedge clk);
      #1;
      check("t3_parked_len", q.size() - base, 12);
      @(negedge clk);
      check("t3_parked_busy", busy, 1'b1);
      finish_frame(base, dbase, "t3");

      // draw_next on first EFB beat keeps band_ready set
      do_reset();
      base = q.size(); dbase = done_cnt;
      draw_at = base + 9;
      pulse_start();
      wait_bytes(base + 16, 100, "t4_second_efb_free");
      draw_at = -1;
      pulse_draw();
      wait_bytes(base + 20, 100, "t4_reach20");
      wait_done(dbase, 50, "t4_done");
      repeat (5) @(posedge clk);
      check_frame(base, "t4");

      // Reset during the third beat of ROM[1] aborts the frame
      do_reset();
      base = q.size(); dbase = done_cnt;
      pulse_start();
      wait_bytes(base + 6, 100, "t5_reach6");
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t5_push_after_rst", out_push, 1'b0);
      check("t5_busy_after_rst", busy, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("t5_aborted_len", (q.size() - base == 6) || (q.size() - base == 7), 1);
      check("t5_no_done", done_cnt - dbase, 0);
      base = q.size(); dbase = done_cnt;
      pulse_start();
      finish_frame(base, dbase, "t5_replay");

      // Looping instance: counter wraps through FFFF -> 0
      @(negedge clk);
      force dut2.frame_cnt_q = 16'hFFFE;
      @(posedge clk);
      @(posedge clk);
      #1 release dut2.frame_cnt_q;
      @(negedge clk);
      check("t6_preload", frame_cnt2, 16'hFFFE);
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int k = 0; k < 100 && q2.size() < 5; k++) @(posedge clk);
      #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int k = 0; k < 400 && cnt2_q.size() < 3; k++) @(posedge clk);
      @(negedge clk);
      check("t6_frames_seen", cnt2_q.size() >= 3, 1);
      check("t6_cnt_frame1", (cnt2_q.size() > 0) ? cnt2_q[0] : 16'hxxxx, 16'hFFFF);
      check("t6_cnt_frame2", (cnt2_q.size() > 1) ? cnt2_q[1] : 16'hxxxx, 16'h0000);
      check("t6_cnt_frame3", (cnt2_q.size() > 2) ? cnt2_q[2] : 16'hxxxx, 16'h0001);
      check("t6_busy_looping", busy2, 1'b1);
      for (int i = 0; i < 40; i++)
         check($sformatf("t6_byte%0d", i), (i < q2.size()) ? q2[i] : 8'hxx, exp_bytes[i % 20]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
